// File: rtl/mdl_xxx_pwm_write_pkg.sv
// mdl_xxx_pwm_write_pkg: shared FSM encodings, default sizes and the read-credit helper for the PWM write-back path
package mdl_xxx_pwm_write_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
   localparam int DEF_DAXI  = 64;
   localparam int DEF_ADDR  = 12;
   localparam int DEF_DRAM  = 32;
   localparam int DEF_WORDS = 2048;
   // A new read may issue only if the FIFO can still take it once the in-flight pair lands
   function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
      return ({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;
   endfunction
endpackage

// File: rtl/mdl_xxx_pwm_write_if.sv
// mdl_xxx_pwm_write_if: coefficient BRAM read ports plus the AXI-Stream master bundle
interface mdl_xxx_pwm_write_if import mdl_xxx_pwm_write_pkg::*; #(
   parameter int PRM_DAXI = DEF_DAXI,
   parameter int PRM_ADDR = DEF_ADDR,
   parameter int PRM_DRAM = DEF_DRAM
);
   logic                oB1_enA;
   logic                oB1_weA;
   logic [PRM_ADDR-1:0] oB1_addrA;
   logic [PRM_DRAM-1:0] iB1_doutA;
   logic                oB1_enB;
   logic                oB1_weB;
   logic [PRM_ADDR-1:0] oB1_addrB;
   logic [PRM_DRAM-1:0] iB1_doutB;
   logic                oTs_Tvalid;
   logic [PRM_DAXI-1:0] oTs_Tdata;
   logic                oTs_Tlast;
   logic                iTs_Tready;
   modport master (
      output oB1_enA, oB1_weA, oB1_addrA, oB1_enB, oB1_weB, oB1_addrB,
      output oTs_Tvalid, oTs_Tdata, oTs_Tlast,
      input  iB1_doutA, iB1_doutB, iTs_Tready
   );
   modport slave (
      input  oB1_enA, oB1_weA, oB1_addrA, oB1_enB, oB1_weB, oB1_addrB,
      input  oTs_Tvalid, oTs_Tdata, oTs_Tlast,
      output iB1_doutA, iB1_doutB, iTs_Tready
   );
endinterface

// File: rtl/mdl_xxx_pwm_write_txfifo.sv
// mdl_xxx_pwm_write_txfifo: 2-entry first-word-fall-through FIFO carrying {last, data}
module mdl_xxx_pwm_write_txfifo #(
   parameter int W = 65
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic [1:0]   occ_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_q, rd_q;
   logic [1:0]   occ_q, occ_d;
   assign occ_d  = occ_q + 2'(push_i) - 2'(pop_i);
   assign dout_o = mem_q[rd_q];
   assign occ_o  = occ_q;
   // Storage and pointers; entries cleared on reset so the stream data reads 0
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) mem_q[wr_q] <= din_i;
         wr_q  <= wr_q ^ push_i;
         rd_q  <= rd_q ^ pop_i;
         occ_q <= occ_d;
      end
endmodule

// File: rtl/mdl_xxx_pwm_write.sv
// mdl_xxx_pwm_write: streams BRAM coefficient pairs {B[2k+1], A[2k]} as AXI-Stream beats after a start pulse
module mdl_xxx_pwm_write import mdl_xxx_pwm_write_pkg::*; #(
   parameter int PRM_DAXI  = DEF_DAXI,
   parameter int PRM_ADDR  = DEF_ADDR,
   parameter int PRM_DRAM  = DEF_DRAM,
   parameter int PRM_WORDS = DEF_WORDS
) (
   input  logic                   iSYS_CLK,
   input  logic                   iSYS_RST,
   input  logic                   iFSM_START,
   output logic                   oFSM_DONE,
   mdl_xxx_pwm_write_if.master    pwm
);
   localparam int KW = $clog2(PRM_WORDS + 1);
   state_e            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic              inflight_q, last_q;
   logic              issue, is_last, pop;
   logic [1:0]        occ;
   logic [PRM_DAXI:0] head;
   assign pop     = pwm.oTs_Tvalid & pwm.iTs_Tready;
   assign is_last = k_q == KW'(PRM_WORDS - 1);
   assign issue   = (state_q == ST_RUN) && credit_ok(occ, inflight_q, pop);
   assign pwm.oB1_enA   = issue;
   assign pwm.oB1_enB   = issue;
   assign pwm.oB1_weA   = 1'b0;
   assign pwm.oB1_weB   = 1'b0;
   assign pwm.oB1_addrA = issue ? PRM_ADDR'({k_q, 1'b0}) : '0;
   assign pwm.oB1_addrB = issue ? PRM_ADDR'({k_q, 1'b1}) : '0;
   assign pwm.oTs_Tvalid = occ != 2'd0;
   assign pwm.oTs_Tdata  = head[PRM_DAXI-1:0];
   assign pwm.oTs_Tlast  = head[PRM_DAXI];
   assign oFSM_DONE      = state_q == ST_DONE;
   // State, pair counter, and the tag of the read whose data returns next cycle
   always_ff @(posedge iSYS_CLK or negedge iSYS_RST)
      if (!iSYS_RST) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         inflight_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         inflight_q <= issue;
         last_q     <= issue & is_last;
      end
   // Next state: run until the final read issues, then drain until the Tlast beat is taken
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         ST_IDLE: begin
            k_d = '0;
            if (iFSM_START) state_d = ST_RUN;
         end
         ST_RUN: if (issue) begin
            k_d = k_q + KW'(1);
            if (is_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (pop && pwm.oTs_Tlast) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end
   mdl_xxx_pwm_write_txfifo #(.W(PRM_DAXI + 1)) u_fifo (
      .clk_i   (iSYS_CLK),
      .rst_n_i (iSYS_RST),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .din_i   ({last_q, pwm.iB1_doutB, pwm.iB1_doutA}),
      .dout_o  (head),
      .occ_o   (occ)
   );
endmodule

// File: tb/tb_mdl_xxx_pwm_write.sv
// tb_mdl_xxx_pwm_write: directed bench for the PWM write-back streamer (2048-beat and 1-beat instances)
module tb_mdl_xxx_pwm_write;
   localparam int W = 2048;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, start1 = 1'b0;
   logic done, done1;
   int n_chk = 0, n_pass = 0, n_fail = 0;
   int k, issues, ndone, cyc, first_v, done_cyc;
   logic hs_last_q, stall_q, last_q;
   logic [63:0] data_q;
   always #5 clk = ~clk;
   mdl_xxx_pwm_write_if #(.PRM_DAXI(64), .PRM_ADDR(12), .PRM_DRAM(32)) bus ();
   mdl_xxx_pwm_write_if #(.PRM_DAXI(64), .PRM_ADDR(12), .PRM_DRAM(32)) bus1 ();
   mdl_xxx_pwm_write #(.PRM_DAXI(64), .PRM_ADDR(12), .PRM_DRAM(32), .PRM_WORDS(W)) u_dut (
      .iSYS_CLK(clk), .iSYS_RST(rst_n), .iFSM_START(start), .oFSM_DONE(done), .pwm(bus.master));
   mdl_xxx_pwm_write #(.PRM_DAXI(64), .PRM_ADDR(12), .PRM_DRAM(32), .PRM_WORDS(1)) u_dut1 (
      .iSYS_CLK(clk), .iSYS_RST(rst_n), .iFSM_START(start1), .oFSM_DONE(done1), .pwm(bus1.master));
   always @(posedge clk) begin
      if (bus.oB1_enA) bus.iB1_doutA <= 32'(bus.oB1_addrA);
      if (bus.oB1_enB) bus.iB1_doutB <= 32'(bus.oB1_addrB);
      if (bus1.oB1_enA) bus1.iB1_doutA <= 32'(bus1.oB1_addrA);
      if (bus1.oB1_enB) bus1.iB1_doutB <= 32'(bus1.oB1_addrB);
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic outputs_zero(input string tag);
      chk({tag, "_en"},   {62'd0, bus.oB1_enA, bus.oB1_enB}, 64'd0);
      chk({tag, "_we"},   {62'd0, bus.oB1_weA, bus.oB1_weB}, 64'd0);
      chk({tag, "_addr"}, {40'd0, bus.oB1_addrA, bus.oB1_addrB}, 64'd0);
      chk({tag, "_vld"},  {61'd0, bus.oTs_Tvalid, bus.oTs_Tlast, done}, 64'd0);
      chk({tag, "_data"}, bus.oTs_Tdata, 64'd0);
      chk({tag, "_vld1"}, {61'd0, bus1.oTs_Tvalid, bus1.oB1_enA, done1}, 64'd0);
   endtask
   task automatic cycle(input logic rdy, input logic st);
      @(negedge clk);
      bus.iTs_Tready = rdy;
      start = st;
      #1;
      cyc++;
      if (bus.oB1_enA) begin
         chk("addrA", 64'(bus.oB1_addrA), 64'(2 * issues));
         chk("addrB", 64'(bus.oB1_addrB), 64'(2 * issues + 1));
         chk("enB", 64'(bus.oB1_enB), 64'd1);
         issues++;
      end
      if (stall_q) begin
         chk("hold_valid", 64'(bus.oTs_Tvalid), 64'd1);
         chk("hold_data", bus.oTs_Tdata, data_q);
         chk("hold_last", 64'(bus.oTs_Tlast), 64'(last_q));
      end
      chk("done", 64'(done), 64'(hs_last_q));
      if (done) begin
         ndone++;
         done_cyc = cyc;
      end
      if (bus.oTs_Tvalid && first_v < 0) first_v = cyc;
      if (bus.oTs_Tvalid && rdy) begin
         chk("tdata", bus.oTs_Tdata, {32'(2 * k + 1), 32'(2 * k)});
         chk("tlast", 64'(bus.oTs_Tlast), 64'(k == W - 1));
         k++;
      end
      hs_last_q = bus.oTs_Tvalid & rdy & bus.oTs_Tlast;
      stall_q   = bus.oTs_Tvalid & ~rdy;
      data_q    = bus.oTs_Tdata;
      last_q    = bus.oTs_Tlast;
   endtask
   task automatic begin_xfer(input logic rdy);
      k = 0; issues = 0; ndone = 0; cyc = 0; first_v = -1; done_cyc = -1;
      hs_last_q = 1'b0; stall_q = 1'b0;
      cycle(rdy, 1'b1);
   endtask
   // mode 0: Tready high; 1: random Tready; 2: Tready low for 100 cycles first
   task automatic xfer(input int mode, input int repulse_at);
      int n;
      begin_xfer(mode == 0);
      n = 1;
      while (ndone == 0 && n < 6000) begin
         cycle(mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (n > 100), n == repulse_at);
         if (mode == 2 && n == 100) begin
            chk("stall_reads", 64'(issues), 64'd2);
            chk("stall_valid", 64'(bus.oTs_Tvalid), 64'd1);
            chk("stall_beat0", bus.oTs_Tdata, 64'h00000001_00000000);
         end
         n++;
      end
      chk("done_seen", 64'(ndone), 64'd1);
      chk("beats", 64'(k), 64'(W));
      if (mode == 0) begin
         chk("first_valid_cyc", 64'(first_v), 64'd4);
         chk("done_cyc", 64'(done_cyc), 64'(W + 4));
      end
      repeat (4) cycle(1'b1, 1'b0);
      chk("idle_done_count", 64'(ndone), 64'd1);
      chk("idle_reads", 64'(issues), 64'(W));
      chk("idle_valid", 64'(bus.oTs_Tvalid), 64'd0);
   endtask
   initial begin
      bus.iTs_Tready = 1'b0;
      bus1.iTs_Tready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      // single-beat instance
      @(negedge clk);
      start1 = 1'b1;
      bus1.iTs_Tready = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      #1;
      chk("w1_en", {62'd0, bus1.oB1_enA, bus1.oB1_enB}, 64'd3);
      chk("w1_addr", {40'd0, bus1.oB1_addrA, bus1.oB1_addrB}, {40'd0, 12'd0, 12'd1});
      @(negedge clk);
      #1;
      chk("w1_en_off", 64'(bus1.oB1_enA), 64'd0);
      chk("w1_novalid", 64'(bus1.oTs_Tvalid), 64'd0);
      @(negedge clk);
      #1;
      chk("w1_valid", {62'd0, bus1.oTs_Tvalid, bus1.oTs_Tlast}, 64'd3);
      chk("w1_data", bus1.oTs_Tdata, 64'h00000001_00000000);
      chk("w1_nodone", 64'(done1), 64'd0);
      @(negedge clk);
      #1;
      chk("w1_done", {62'd0, done1, bus1.oTs_Tvalid}, 64'd2);
      @(negedge clk);
      #1;
      chk("w1_idle", {61'd0, done1, bus1.oTs_Tvalid, bus1.oB1_enA}, 64'd0);
      // full-length instance
      xfer(0, -1);
      xfer(1, -1);
      xfer(2, -1);
      xfer(0, 10);
      begin_xfer(1'b1);
      while (k < 700 && cyc < 1000) cycle(1'b1, 1'b0);
      chk("pre_reset_beats", 64'(k), 64'd700);
      #2;
      rst_n = 1'b0;
      #1;
      outputs_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      xfer(0, -1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
